gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for the board's registered two-input logic gate (clk/a/b/f datapath). On a start request it drives all four input vectors into the gate, waits out the gate's register latency, compares `f` against the expected function and reports an error count and pass/fail. It sits between the DE2 user I/O (key/switch start, LED results) and the gate instance, replacing hand-driven stimulus.

## Interface
- `LAT`, 1: gate output latency in clk cycles from a/b change to valid f.
- `HOLD`, 2: cycles each vector is held; must satisfy HOLD > LAT (elaboration-time check).
- `OP`, OP_AND: expected gate function, from package op codes (AND, OR, XOR).
- `ERR_W`, 3: error counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, level-sampled in IDLE only.
- `gate_a` out 1: gate input a, registered.
- `gate_b` out 1: gate input b, registered.
- `gate_f` in 1: gate output under test.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: last run had zero mismatches; valid from `done` until next start.
- `err_cnt` out ERR_W: mismatches in last/current run, saturating.
- `vec_idx` out 2: current vector index; {gate_a,gate_b} = vec_idx.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: start=1 at an edge -> APPLY; vec_idx=0, hold counter=0, err_cnt=0, pass=0, busy=1.
- APPLY: gate_a=vec_idx[1], gate_b=vec_idx[0]; vector order 00,01,10,11. Hold counter counts 0..HOLD-1.
- Check: when hold counter = HOLD-1, compare gate_f with expected = OP(gate_a,gate_b); mismatch -> err_cnt+1, saturating at 2^ERR_W-1.
- Same cycle: if vec_idx=3 -> DONE, else vec_idx+1, counter=0.
- DONE: busy=0, done=1, pass=(err_cnt==0 including final check), gate_a/gate_b -> 0; next edge -> IDLE.
- start ignored in APPLY and DONE; held high through DONE starts a new run from IDLE on the following edge.
- Reset values: gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0, state IDLE.
- rst mid-run: next edge forces reset values; no done pulse; run abandoned.

## Timing
- start sampled at edge k: vector 00 visible after edge k.
- Each vector occupies exactly HOLD cycles; gate_f sampled at the edge ending the vector, i.e. HOLD >= LAT+1 cycles after application.
- DONE entered at edge k+4*HOLD; done high for exactly that cycle; busy low from same edge.
- err_cnt, pass stable from DONE until next accepted start.
- Minimum start-to-start: 4*HOLD+2 cycles.

## Structure
- Shared package `gate_bist_pkg`: state enum (IDLE, APPLY, DONE), op codes OP_AND/OP_OR/OP_XOR, expected-function helper.
- Single module; no sub-module. Hold counter width derived from HOLD.

## Test plan
- Reset: rst high 3 cycles mid-run -> all outputs 0, IDLE; no done.
- Good AND gate (LAT=1, HOLD=2, OP_AND): start pulse at edge k -> vectors 00,01,10,11 at 2 cycles each, done at edge k+8, pass=1, err_cnt=0.
- Stuck-at-1 gate_f -> err_cnt=3, pass=0.
- OR gate with OP_AND -> mismatches at 01 and 10, err_cnt=2, pass=0.
- start re-pulsed during busy -> ignored, single done; start held high -> back-to-back runs 10 cycles apart.
- ERR_W=1, stuck-at-1 -> err_cnt saturates at 1, pass=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_pkg
// Description : Shared types for the gate BIST sequencer: FSM state encoding,
//               gate operation codes and the expected-function helper used to
//               grade the gate output.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } bist_state_e;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } gate_op_e;

    // Reference model of the gate under test.
    function automatic logic gate_expect(input gate_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_ctrl
// Description : Built-in self-test sequencer for a registered two-input gate.
//               On start it walks the four input vectors 00,01,10,11, holds
//               each for HOLD cycles, grades gate_f at the last cycle of each
//               vector and reports a saturating mismatch count and pass/fail.
// Ports       : clk, rst (sync, active high)
//               start          - run request, sampled only in IDLE
//               gate_a, gate_b - registered stimulus to the gate
//               gate_f         - gate output under test
//               busy, done     - run in progress / one-cycle completion pulse
//               pass, err_cnt  - result of last run (held until next start)
//               vec_idx        - current vector, equals {gate_a, gate_b}
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned LAT   = 1,
    parameter int unsigned HOLD  = 2,
    parameter gate_op_e    OP    = OP_AND,
    parameter int unsigned ERR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int unsigned         c_HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD - 1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

    // gate_f must have settled before the grading edge of each vector.
    if (HOLD <= LAT) begin : g_bad_hold
        $error("gate_bist_ctrl: HOLD must exceed LAT");
    end

    bist_state_e         r_state,   w_state_nxt;
    logic                r_gate_a,  w_gate_a_nxt;
    logic                r_gate_b,  w_gate_b_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_pass,    w_pass_nxt;
    logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic [1:0]          r_vec_idx, w_vec_idx_nxt;
    logic [c_HOLD_W-1:0] r_hold,    w_hold_nxt;

    logic                w_check;
    logic                w_mismatch;
    logic [ERR_W-1:0]    w_err_upd;
    logic [1:0]          w_vec_inc;

    // Grading uses the registered stimulus, i.e. the vector the gate has
    // been seeing for the whole hold window.
    assign w_check    = (r_state == APPLY) && (r_hold == c_HOLD_LAST);
    assign w_mismatch = w_check && (gate_f != gate_expect(OP, r_gate_a, r_gate_b));
    assign w_err_upd  = (w_mismatch && (r_err_cnt != c_ERR_MAX)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
    assign w_vec_inc  = r_vec_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gate_a  <= 1'b0;
            r_gate_b  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_vec_idx <= 2'd0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gate_a  <= w_gate_a_nxt;
            r_gate_b  <= w_gate_b_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_vec_idx <= w_vec_idx_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gate_a_nxt  = r_gate_a;
        w_gate_b_nxt  = r_gate_b;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = r_pass;
        w_err_cnt_nxt = r_err_cnt;
        w_vec_idx_nxt = r_vec_idx;
        w_hold_nxt    = r_hold;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = APPLY;
                    w_gate_a_nxt  = 1'b0;
                    w_gate_b_nxt  = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_pass_nxt    = 1'b0;
                    w_err_cnt_nxt = '0;
                    w_vec_idx_nxt = 2'd0;
                    w_hold_nxt    = '0;
                end
            end

            APPLY: begin
                w_err_cnt_nxt = w_err_upd;
                if (w_check) begin
                    w_hold_nxt = '0;
                    if (r_vec_idx == 2'd3) begin
                        // Final grade folds into pass in the same cycle.
                        w_state_nxt   = DONE;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_pass_nxt    = (w_err_upd == '0);
                        w_gate_a_nxt  = 1'b0;
                        w_gate_b_nxt  = 1'b0;
                        w_vec_idx_nxt = 2'd0;
                    end else begin
                        w_vec_idx_nxt = w_vec_inc;
                        w_gate_a_nxt  = w_vec_inc[1];
                        w_gate_b_nxt  = w_vec_inc[0];
                    end
                end else begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign gate_a  = r_gate_a;
    assign gate_b  = r_gate_b;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
    assign vec_idx = r_vec_idx;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_bist_ctrl
// Description : Self-checking bench for gate_bist_ctrl. A one-cycle registered
//               gate model with selectable faults feeds the main instance; a
//               second instance with ERR_W=1 sees a stuck-at-1 output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam int c_HOLD = 2;
    localparam int c_RUN  = 4 * c_HOLD;

    // Gate model modes
    localparam int c_M_AND = 0;
    localparam int c_M_S1  = 1;
    localparam int c_M_OR  = 2;
    localparam int c_M_XOR = 3;
    localparam int c_M_S0  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       gate_a, gate_b, gate_f;
    logic       busy, done, pass;
    logic [2:0] err_cnt;
    logic [1:0] vec_idx;

    logic       s1_f = 1'b1;
    logic       gate_a2, gate_b2, busy2, done2, pass2;
    logic [0:0] err_cnt2;
    logic [1:0] vec_idx2;

    int mode = c_M_AND;
    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Registered gate under test, LAT = 1.
    always_ff @(posedge clk) begin
        case (mode)
            c_M_AND: gate_f <= gate_a & gate_b;
            c_M_S1:  gate_f <= 1'b1;
            c_M_OR:  gate_f <= gate_a | gate_b;
            c_M_XOR: gate_f <= gate_a ^ gate_b;
            default: gate_f <= 1'b0;
        endcase
    end

    gate_bist_ctrl #(.LAT(1), .HOLD(c_HOLD), .OP(OP_AND), .ERR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .gate_a(gate_a), .gate_b(gate_b), .gate_f(gate_f),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .vec_idx(vec_idx)
    );

    gate_bist_ctrl #(.LAT(1), .HOLD(c_HOLD), .OP(OP_AND), .ERR_W(1)) dut_w1 (
        .clk(clk), .rst(rst), .start(start),
        .gate_a(gate_a2), .gate_b(gate_b2), .gate_f(s1_f),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .vec_idx(vec_idx2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then follow the run cycle by cycle.
    task automatic run_check(input string nm, input int m, input int exp_err, input bit exp_pass);
        mode = m;
        start = 1'b1;
        tick();                 // edge k
        start = 1'b0;
        chk({nm, " busy@k"}, busy, 1);
        chk({nm, " vec@k"}, vec_idx, 0);
        chk({nm, " ab@k"}, {gate_a, gate_b}, 0);
        for (int c = 1; c <= c_RUN + 1; c++) begin
            tick();
            if (c < c_RUN) begin
                chk({nm, " vec"}, vec_idx, c / c_HOLD);
                chk({nm, " ab"}, {gate_a, gate_b}, c / c_HOLD);
                chk({nm, " busy"}, busy, 1);
                chk({nm, " done_early"}, done, 0);
            end else if (c == c_RUN) begin
                chk({nm, " done"}, done, 1);
                chk({nm, " busy_end"}, busy, 0);
                chk({nm, " err_cnt"}, err_cnt, exp_err);
                chk({nm, " pass"}, pass, exp_pass);
                chk({nm, " ab_end"}, {gate_a, gate_b}, 0);
                chk({nm, " w1_done"}, done2, 1);
                chk({nm, " w1_err_sat"}, err_cnt2, 1);
                chk({nm, " w1_pass"}, pass2, 0);
            end else begin
                chk({nm, " done_pulse"}, done, 0);
                chk({nm, " err_hold"}, err_cnt, exp_err);
                chk({nm, " pass_hold"}, pass, exp_pass);
            end
        end
    endtask

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        bit    exp_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int ndone;
        int first_done;
        int second_done;

        tbl[0] = '{"and_good",  c_M_AND, 0, 1'b1};
        tbl[1] = '{"stuck1",    c_M_S1,  3, 1'b0};
        tbl[2] = '{"or_gate",   c_M_OR,  2, 1'b0};
        tbl[3] = '{"xor_gate",  c_M_XOR, 3, 1'b0};
        tbl[4] = '{"stuck0",    c_M_S0,  1, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err", err_cnt, 0);
        chk("rst vec", vec_idx, 0);
        chk("rst ab", {gate_a, gate_b}, 0);
        chk("rst w1 err", err_cnt2, 0);
        tick();
        chk("idle no start", busy, 0);

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            run_check(tbl[i].name, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_pass);
            tick();
        end

        // Reset mid-run: abandon, no done pulse
        mode = c_M_S1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst busy", busy, 0);
        chk("midrst err", err_cnt, 0);
        chk("midrst vec", vec_idx, 0);
        chk("midrst ab", {gate_a, gate_b}, 0);
        chk("midrst pass", pass, 0);
        chk("midrst done", done, 0);
        repeat (2) tick();
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        chk("midrst idle", busy, 0);

        // start re-pulsed while busy: ignored, single done at k+8
        mode = c_M_AND;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 3) || (c == c_RUN);
            tick();
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        start = 1'b0;
        chk("repulse ndone", ndone, 1);
        chk("repulse done_at", first_done, c_RUN);
        chk("repulse pass", pass, 1);

        // start held high: back-to-back runs 4*HOLD+2 apart
        start = 1'b1;
        tick();
        ndone = 0;
        first_done = -1;
        second_done = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        chk("held ndone", ndone, 2);
        chk("held first", first_done, c_RUN);
        chk("held spacing", second_done - first_done, c_RUN + 2);
        chk("held busy", busy, 1);
        repeat (10) tick();
        chk("held idle", busy, 0);
        chk("held pass", pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
